// File: rtl/des_pkg.sv
// Shared DES datapath types and constants.
// Imported by the half-block registers of the round loop.
package des_pkg;

  localparam int DES_HALF_W = 32;
  localparam int DES_ROUNDS = 16;

  typedef logic [DES_HALF_W-1:0] des_half_t;

  localparam des_half_t DES_HALF_RST = '0;

endpackage

// File: rtl/des_ld_en_reg.sv
// Generic register with priority load/enable input select.
// Load beats enable; neither asserted holds the current value.
module des_ld_en_reg #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] ld_data_i,
  input  logic [WIDTH-1:0] en_data_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    priority case (1'b1)
      ld_i:    q_d = ld_data_i;
      en_i:    q_d = en_data_i;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= RST_VAL;
    else        q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/des_left_reg.sv
// DES left-half round register: L0 load, Feistel swap L <= R_prev.
// DES_LEFT_REG_ROUND_CNT_EN adds a saturating rounds-since-load counter.
module des_left_reg
  import des_pkg::*;
#(
  parameter int WIDTH   = DES_HALF_W,
  parameter int ROUND_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               load_init,
  input  logic [WIDTH-1:0]   L_0,
  input  logic [WIDTH-1:0]   R_prev,
`ifdef DES_LEFT_REG_ROUND_CNT_EN
  output logic [ROUND_W-1:0] round_cnt,
`endif
  output logic [WIDTH-1:0]   L_curr
);

  des_ld_en_reg #(
    .WIDTH   (WIDTH),
    .RST_VAL (WIDTH'(DES_HALF_RST))
  ) u_l_reg (
    .clk       (clk),
    .rst_n     (rst),
    .ld_i      (load_init),
    .en_i      (en),
    .ld_data_i (L_0),
    .en_data_i (R_prev),
    .q_o       (L_curr)
  );

`ifdef DES_LEFT_REG_ROUND_CNT_EN
  logic [ROUND_W-1:0] cnt_q;
  logic [ROUND_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_init)
      cnt_d = '0;
    else if (en && cnt_q != '1)
      cnt_d = cnt_q + ROUND_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign round_cnt = cnt_q;
`else
  logic [ROUND_W-1:0] unused_round_w;
  assign unused_round_w = '0;
`endif

endmodule

// File: tb/tb_des_left_reg.sv
// Directed self-checking bench for des_left_reg.
module tb_des_left_reg;

  logic        clk;
  logic        rst;
  logic        en;
  logic        load_init;
  logic [31:0] L_0;
  logic [31:0] R_prev;
  logic [31:0] L_curr;
`ifdef DES_LEFT_REG_ROUND_CNT_EN
  logic [4:0]  round_cnt;
`endif

  int checks;
  int errors;

  des_left_reg #(
    .WIDTH   (32),
    .ROUND_W (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load_init (load_init),
    .L_0       (L_0),
    .R_prev    (R_prev),
`ifdef DES_LEFT_REG_ROUND_CNT_EN
    .round_cnt (round_cnt),
`endif
    .L_curr    (L_curr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_l(input string name, input logic [31:0] exp);
    checks++;
    if (L_curr !== exp) begin
      errors++;
      $display("FAIL %s: L_curr=%h expected %h", name, L_curr, exp);
    end
  endtask

`ifdef DES_LEFT_REG_ROUND_CNT_EN
  task automatic chk_cnt(input string name, input logic [4:0] exp);
    checks++;
    if (round_cnt !== exp) begin
      errors++;
      $display("FAIL %s: round_cnt=%0d expected %0d", name, round_cnt, exp);
    end
  endtask
`endif

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; load_init = 1'b0;
    L_0 = 32'h1234_5678; R_prev = 32'h9ABC_DEF0;
    step(); step();
    chk_l("reset_hold", 32'h0000_0000);
`ifdef DES_LEFT_REG_ROUND_CNT_EN
    chk_cnt("reset_cnt", 5'd0);
`endif
    rst = 1'b1;
    step();
    chk_l("reset_release", 32'h0000_0000);
  endtask

  task automatic test_load();
    L_0 = 32'hAAAA_5555; load_init = 1'b1;
    step();
    load_init = 1'b0; L_0 = 32'h0BAD_0BAD;
    chk_l("load", 32'hAAAA_5555);
    step();
    chk_l("load_hold1", 32'hAAAA_5555);
    step();
    chk_l("load_hold2", 32'hAAAA_5555);
  endtask

  task automatic test_shift();
    logic [31:0] vals [3];
    vals[0] = 32'hDEAD_BEEF;
    vals[1] = 32'hCAFE_BABE;
    vals[2] = 32'h0123_4567;
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      R_prev = vals[i];
      step();
      chk_l($sformatf("shift%0d", i), vals[i]);
    end
`ifdef DES_LEFT_REG_ROUND_CNT_EN
    chk_cnt("shift_cnt", 5'd3);
`endif
    en = 1'b0;
  endtask

  task automatic test_hold();
    R_prev = 32'h89AB_CDEF;
    step();
    chk_l("hold1", 32'h0123_4567);
    R_prev = 32'h1357_9BDF;
    L_0 = 32'hFFFF_FFFF;
    step();
    chk_l("hold2", 32'h0123_4567);
  endtask

  task automatic test_load_priority();
    en = 1'b1; load_init = 1'b1;
    L_0 = 32'h1111_2222; R_prev = 32'h5555_6666;
    step();
    chk_l("prio_load", 32'h1111_2222);
`ifdef DES_LEFT_REG_ROUND_CNT_EN
    chk_cnt("prio_cnt", 5'd0);
`endif
    load_init = 1'b0;
    step();
    chk_l("prio_shift", 32'h5555_6666);
`ifdef DES_LEFT_REG_ROUND_CNT_EN
    chk_cnt("prio_cnt1", 5'd1);
`endif
    en = 1'b0;
  endtask

  task automatic test_back_to_back();
    load_init = 1'b1; L_0 = 32'h3333_4444;
    step();
    chk_l("b2b_load1", 32'h3333_4444);
    L_0 = 32'h7777_8888;
    step();
    chk_l("b2b_load2", 32'h7777_8888);
    load_init = 1'b0;
  endtask

  task automatic test_async_reset();
    #2;
    rst = 1'b0;
    #1;
    chk_l("async_clr", 32'h0000_0000);
    step();
    chk_l("async_held", 32'h0000_0000);
    rst = 1'b1;
    step();
    chk_l("async_release", 32'h0000_0000);
    L_0 = 32'hFEDC_BA98; load_init = 1'b1;
    step();
    chk_l("async_reload", 32'hFEDC_BA98);
    load_init = 1'b0; en = 1'b1; R_prev = 32'h0F0F_F0F0;
    step();
    chk_l("async_shift", 32'h0F0F_F0F0);
    en = 1'b0;
  endtask

`ifdef DES_LEFT_REG_ROUND_CNT_EN
  task automatic test_saturate();
    load_init = 1'b1;
    step();
    load_init = 1'b0; en = 1'b1;
    for (int i = 0; i < 40; i++) step();
    chk_cnt("cnt_sat", 5'd31);
    en = 1'b0;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_load();
    test_shift();
    test_hold();
    test_load_priority();
    test_back_to_back();
    test_async_reset();
`ifdef DES_LEFT_REG_ROUND_CNT_EN
    test_saturate();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
